// File: rtl/chop_pkg.sv
// Shared types and helpers for the chopper demodulator/integrator.
// Holds the FSM encoding, held-counter width and a width-generic saturating adder.
package chop_pkg;

    localparam int unsigned HELD_CNT_W = 16;
    localparam int unsigned SAT_MAX_W  = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StSat  = 2'd2
    } chop_state_e;

    typedef struct packed {
        logic                 clamp;
        logic [SAT_MAX_W-1:0] sum;
    } sat_res_t;

    // Signed a + b clamped to the range of a `width`-bit signed value (width <= SAT_MAX_W).
    function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                         input logic signed [SAT_MAX_W-1:0] b,
                                         input int unsigned                 width);
        logic signed [SAT_MAX_W:0] s;
        logic signed [SAT_MAX_W:0] one;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        sat_res_t                  r;
        one    = '0;
        one[0] = 1'b1;
        s      = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
        hi     = (one <<< (width - 1)) - one;
        lo     = ~hi;
        if (s > hi) begin
            r.clamp = 1'b1;
            r.sum   = hi[SAT_MAX_W-1:0];
        end else if (s < lo) begin
            r.clamp = 1'b1;
            r.sum   = lo[SAT_MAX_W-1:0];
        end else begin
            r.clamp = 1'b0;
            r.sum   = s[SAT_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Stage-3 clamped accumulator: adds din_i when enabled and not held, pinning at the
// signed range limits. clamp_o flags that the update taken at this edge clamps.
module sat_accum
    import chop_pkg::*;
#(
    parameter int unsigned IN_W  = 19,
    parameter int unsigned ACC_W = 40,
    parameter int unsigned OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic                    hold_i,
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] acc_top_o,
    output logic                    clamp_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    sat_res_t                res;

    always_comb begin
        res     = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(din_i), ACC_W);
        acc_d   = acc_q;
        clamp_o = 1'b0;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i && !hold_i) begin
            acc_d   = ACC_W'(res.sum);
            clamp_o = res.clamp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_top_o = acc_q[ACC_W-1 -: OUT_W];

endmodule

// File: rtl/chop_demod_integ.sv
// Chopper demodulator and saturating integrator for one ADC channel: offset removal,
// chop-phase sign restoration and integration with held samples excluded and counted.
module chop_demod_integ
    import chop_pkg::*;
#(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned OUT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         integ_en,
    input  logic                         chop_default,
    input  logic                         chop_i,
    input  logic                         hold_i,
    input  logic signed [DATA_W-1:0]     offset_i,
    input  logic signed [DATA_W-1:0]     data_i,
    input  logic                         data_valid_i,
    output logic signed [DATA_W:0]       demod_o,
    output logic                         demod_valid_o,
    output logic signed [OUT_W-1:0]      integral_o,
    output logic                         integral_valid_o,
    output logic                         sat_o,
    output logic [HELD_CNT_W-1:0]        held_cnt_o
);

    localparam int unsigned DEMOD_W = DATA_W + 1;

    chop_state_e state_q, state_d;

    logic                      s1_valid_q, s1_valid_d;
    logic signed [DEMOD_W-1:0] s1_diff_q, s1_diff_d;
    logic                      s1_inv_q, s1_inv_d;
    logic                      s1_hold_q, s1_hold_d;
    logic                      s2_valid_q, s2_valid_d;
    logic signed [DEMOD_W-1:0] demod_q, demod_d;
    logic                      s2_hold_q, s2_hold_d;
    logic                      ival_q, ival_d;
    logic [HELD_CNT_W-1:0]     held_cnt_q, held_cnt_d;
    logic                      clamp;

    // Dropping integ_en flushes the whole pipeline in one edge so no stale strobes follow.
    always_comb begin
        s1_valid_d = 1'b0;
        s1_diff_d  = s1_diff_q;
        s1_inv_d   = s1_inv_q;
        s1_hold_d  = s1_hold_q;
        s2_valid_d = 1'b0;
        demod_d    = demod_q;
        s2_hold_d  = s2_hold_q;
        ival_d     = 1'b0;
        held_cnt_d = held_cnt_q;
        if (!integ_en) begin
            s1_diff_d  = '0;
            s1_inv_d   = 1'b0;
            s1_hold_d  = 1'b0;
            demod_d    = '0;
            s2_hold_d  = 1'b0;
            held_cnt_d = '0;
        end else begin
            s1_valid_d = data_valid_i;
            if (data_valid_i) begin
                s1_diff_d = DEMOD_W'(data_i) - DEMOD_W'(offset_i);
                s1_inv_d  = chop_i ^ chop_default;
                s1_hold_d = hold_i;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                demod_d   = s1_inv_q ? -s1_diff_q : s1_diff_q;
                s2_hold_d = s1_hold_q;
            end
            ival_d = s2_valid_q;
            if (s2_valid_q && s2_hold_q && held_cnt_q != '1) begin
                held_cnt_d = held_cnt_q + HELD_CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StRun;
            StRun:   if (clamp) state_d = StSat;
            StSat:   state_d = StSat;
            default: state_d = StIdle;
        endcase
        if (!integ_en) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_inv_q   <= 1'b0;
            s1_hold_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            demod_q    <= '0;
            s2_hold_q  <= 1'b0;
            ival_q     <= 1'b0;
            held_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_inv_q   <= s1_inv_d;
            s1_hold_q  <= s1_hold_d;
            s2_valid_q <= s2_valid_d;
            demod_q    <= demod_d;
            s2_hold_q  <= s2_hold_d;
            ival_q     <= ival_d;
            held_cnt_q <= held_cnt_d;
        end
    end

    sat_accum #(
        .IN_W  (DEMOD_W),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!integ_en),
        .en_i      (integ_en && s2_valid_q),
        .hold_i    (s2_hold_q),
        .din_i     (demod_q),
        .acc_top_o (integral_o),
        .clamp_o   (clamp)
    );

    assign demod_o          = demod_q;
    assign demod_valid_o    = s2_valid_q;
    assign integral_valid_o = ival_q;
    assign sat_o            = (state_q == StSat);
    assign held_cnt_o       = held_cnt_q;

endmodule

// File: tb/tb_chop_demod_integ.sv
// Bench for chop_demod_integ: directed scenarios plus randomized traffic, all checked
// every cycle against an arithmetic model of the demodulator and integrator.
module tb_chop_demod_integ;

    localparam int unsigned DATA_W = 18;
    // Narrower accumulator so clamping is reachable in a short run; integral is still acc>>8.
    localparam int unsigned ACC_W  = 28;
    localparam int unsigned OUT_W  = 20;
    localparam int unsigned SHIFT  = ACC_W - OUT_W;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     integ_en = 1'b0;
    logic                     chop_default = 1'b0;
    logic                     chop_i = 1'b0;
    logic                     hold_i = 1'b0;
    logic signed [DATA_W-1:0] offset_i = '0;
    logic signed [DATA_W-1:0] data_i = '0;
    logic                     data_valid_i = 1'b0;
    logic signed [DATA_W:0]   demod_o;
    logic                     demod_valid_o;
    logic signed [OUT_W-1:0]  integral_o;
    logic                     integral_valid_o;
    logic                     sat_o;
    logic [15:0]              held_cnt_o;

    int n_tests = 0;
    int n_fail = 0;
    int dval_cnt = 0;
    int ival_cnt = 0;

    chop_demod_integ #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .integ_en         (integ_en),
        .chop_default     (chop_default),
        .chop_i           (chop_i),
        .hold_i           (hold_i),
        .offset_i         (offset_i),
        .data_i           (data_i),
        .data_valid_i     (data_valid_i),
        .demod_o          (demod_o),
        .demod_valid_o    (demod_valid_o),
        .integral_o       (integral_o),
        .integral_valid_o (integral_valid_o),
        .sat_o            (sat_o),
        .held_cnt_o       (held_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample accepted at edge n shows on demod_o after n+1 and is
    // folded into the integral after n+2.
    typedef struct {
        bit     v;
        bit     h;
        longint d;
    } samp_t;

    samp_t  p1, p2;
    longint m_acc = 0;
    longint m_demod = 0;
    int     m_held = 0;
    bit     m_sat = 0;
    bit     m_dval = 0;
    bit     m_ival = 0;

    always @(posedge clk or negedge rst_n) begin
        longint t;
        if (!rst_n || !integ_en) begin
            p1 = '{0, 0, 0};
            p2 = '{0, 0, 0};
            m_acc = 0; m_demod = 0; m_held = 0; m_sat = 0; m_dval = 0; m_ival = 0;
        end else begin
            m_ival = p2.v;
            m_dval = p1.v;
            if (p2.v) begin
                if (p2.h) begin
                    if (m_held < 65535) m_held++;
                end else begin
                    t = m_acc + p2.d;
                    if (t > ACC_MAX) begin t = ACC_MAX; m_sat = 1; end
                    if (t < ACC_MIN) begin t = ACC_MIN; m_sat = 1; end
                    m_acc = t;
                end
            end
            if (p1.v) m_demod = p1.d;
            p2 = p1;
            p1.v = data_valid_i;
            p1.h = hold_i;
            p1.d = longint'(data_i) - longint'(offset_i);
            if (chop_i != chop_default) p1.d = -p1.d;
        end
    end

    always @(negedge clk) begin
        chk("demod_valid", demod_valid_o, m_dval);
        chk("demod", demod_o, m_demod);
        chk("integral_valid", integral_valid_o, m_ival);
        chk("integral", integral_o, m_acc >>> SHIFT);
        chk("sat", sat_o, m_sat);
        chk("held_cnt", held_cnt_o, m_held);
        if (demod_valid_o) dval_cnt++;
        if (integral_valid_o) ival_cnt++;
    end

    task automatic step(input bit en, input bit dv, input int d, input int o,
                        input bit c, input bit h);
        @(negedge clk);
        integ_en     = en;
        data_valid_i = dv;
        data_i       = DATA_W'(d);
        offset_i     = DATA_W'(o);
        chop_i       = c;
        hold_i       = h;
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_run();
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    logic [31:0] rnd;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_integral", integral_o, 0);
        chk("rst_demod_valid", demod_valid_o, 0);
        chk("rst_sat", sat_o, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Constant input, non-inverted phase
        for (int i = 0; i < 10; i++) step(1, 1, 1000, 0, 0, 0);
        flush(4);
        chk("t1_integral", integral_o, 39);
        chk("t1_model_acc", m_acc, 10000);
        chk("t1_held", held_cnt_o, 0);

        // Alternating chop halves
        clear_run();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 5; i++) step(1, 1, 1000, 0, 0, 0);
            flush(4);
            chk("t2_half_integral", integral_o, 19);
            for (int i = 0; i < 5; i++) step(1, 1, 1000, 0, 1, 0);
            flush(4);
            chk("t2_period_integral", integral_o, 0);
        end

        // Hold exclusion with inverted phase and negative data
        clear_run();
        ival_cnt = 0;
        for (int i = 0; i < 3; i++) step(1, 1, -1000, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 1, -1000, 0, 1, 0);
        flush(4);
        chk("t3_held", held_cnt_o, 3);
        chk("t3_integral", integral_o, 15);
        chk("t3_model_acc", m_acc, 4000);
        chk("t3_ival_pulses", ival_cnt, 7);

        // Positive saturation, then one idle cycle clears it
        clear_run();
        for (int i = 0; i < 600; i++) step(1, 1, 131071, -131072, 0, 0);
        flush(4);
        chk("t4_integral", integral_o, 524287);
        chk("t4_sat", sat_o, 1);
        chk("t4_state", u_dut.state_q, 2);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t4_sat_cleared", sat_o, 0);
        chk("t4_integral_cleared", integral_o, 0);

        // Abort: integ_en drops right after a sample
        flush(3);
        dval_cnt = 0;
        ival_cnt = 0;
        step(1, 1, 500, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t5_integral_after_abort", integral_o, 0);
        flush(4);
        chk("t5_no_demod_valid", dval_cnt, 0);
        chk("t5_no_integral_valid", ival_cnt, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1, 1, 2000, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_demod", demod_o, 0);
        chk("t5_rst_demod_valid", demod_valid_o, 0);
        chk("t5_rst_integral", integral_o, 0);
        chk("t5_rst_integral_valid", integral_valid_o, 0);
        data_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Offset removal
        clear_run();
        for (int i = 0; i < 10; i++) step(1, 1, 5000, 5000, i[0], 0);
        flush(4);
        chk("t6_integral", integral_o, 0);
        chk("t6_model_acc", m_acc, 0);

        // Random: drive to positive clamp, then negative via inverted phase, then free-run
        clear_run();
        for (int i = 0; i < 2500; i++) begin
            rnd = $urandom;
            step(1, rnd[1:0] != 0, 100000 + int'(rnd[14:0]), 0, 0, rnd[4:2] == 0);
        end
        for (int i = 0; i < 4000; i++) begin
            rnd = $urandom;
            step(1, rnd[1:0] != 0, 100000 + int'(rnd[14:0]), 0, 1, rnd[4:2] == 0);
        end
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom;
            data_i = rnd[17:0];
            step(($urandom % 200) != 0, rnd[19:18] != 0, int'(data_i),
                 int'($signed(rnd[31:24])) * 64, rnd[20], rnd[23:21] == 0);
        end
        flush(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
